// File: rtl/tlul_arbiter_wrr_pkg.sv
// Shared constants and helpers for the weighted round-robin TL-UL A-channel arbiter.
// The socket reads ArbiterImpl to decide which arbiter flavour to instantiate.
package tlul_arbiter_wrr_pkg;

    localparam int ArbWeightW = 4;

    typedef enum logic [1:0] {
        ArbPpc  = 2'd0,
        ArbTree = 2'd1,
        ArbWrr  = 2'd2
    } arbiter_impl_e;

    localparam arbiter_impl_e ArbiterImpl = ArbWrr;

    // A programmed weight of zero would starve its host, so it is promoted to one.
    function automatic logic [ArbWeightW-1:0] eff_weight(input logic [ArbWeightW-1:0] w);
        return (w == '0) ? ArbWeightW'(1) : w;
    endfunction

endpackage

// File: rtl/tlul_outstanding_cnt.sv
// Per-host in-flight transaction counter: increments on A accept, decrements on D accept.
// A decrement at zero (without a matching increment) leaves the count at zero and flags underflow.
module tlul_outstanding_cnt
    import tlul_arbiter_wrr_pkg::*;
#(
    parameter int MaxOutstanding = 4,
    localparam int CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] cnt_o,
    output logic            at_max_o,
    output logic            underflow_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d       = cnt_q;
        underflow_o = dec_i & ~inc_i & (cnt_q == '0);
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign at_max_o = (cnt_q >= CntW'(MaxOutstanding));

endmodule

// File: rtl/tlul_arbiter_wrr.sv
// Weighted round-robin A-channel arbiter with per-host outstanding limits.
// A presented request is locked until accepted so idx_o/data_o never change under back-pressure.
module tlul_arbiter_wrr
    import tlul_arbiter_wrr_pkg::*;
#(
    parameter int N = 4,
    parameter int DW = 32,
    parameter int MaxOutstanding = 4,
    parameter logic [N*ArbWeightW-1:0] Weights = {N{4'h1}},
    localparam int IdxW = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic [N*DW-1:0] data_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o,
    output logic [DW-1:0]   data_o,
    input  logic            ready_i,
    input  logic            rsp_valid_i,
    input  logic            rsp_ready_i,
    input  logic [IdxW-1:0] rsp_id_i,
    output logic            idle_o,
    output logic            err_o
);

    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic [IdxW-1:0]       lock_idx_q, lock_idx_d;
    logic [ArbWeightW-1:0] cred_q, cred_d;
    logic                  lock_q, lock_d;
    logic                  err_q, err_d;

    logic [N-1:0]    eligible, at_max, underflow, busy;
    logic [IdxW-1:0] sel;
    logic            found;
    int              scan;
    logic            accept, rsp_fire, bad_id;

    assign accept   = valid_o & ready_i;
    assign rsp_fire = rsp_valid_i & rsp_ready_i;
    assign bad_id   = rsp_fire & (int'(rsp_id_i) >= N);

    for (genvar i = 0; i < N; i++) begin : g_host
        logic [CntW-1:0] cnt;

        assign gnt_o[i] = accept & (sel == IdxW'(i));

        tlul_outstanding_cnt #(
            .MaxOutstanding(MaxOutstanding)
        ) u_cnt (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .inc_i      (gnt_o[i]),
            .dec_i      (rsp_fire & (rsp_id_i == IdxW'(i))),
            .cnt_o      (cnt),
            .at_max_o   (at_max[i]),
            .underflow_o(underflow[i])
        );

        assign busy[i]     = |cnt;
        assign eligible[i] = req_i[i] & ~at_max[i];
    end

    // Priority: held request, then continuing burst, then rotating scan starting after ptr.
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        scan  = 0;
        if (lock_q) begin
            sel = lock_idx_q;
        end else if ((cred_q != '0) && eligible[ptr_q]) begin
            sel = ptr_q;
        end else begin
            for (int k = 1; k <= N; k++) begin
                scan = (int'(ptr_q) + k) % N;
                if (!found && eligible[scan]) begin
                    sel   = IdxW'(scan);
                    found = 1'b1;
                end
            end
        end
    end

    assign valid_o = lock_q | (|eligible);
    assign idx_o   = sel;
    assign data_o  = data_i[sel*DW +: DW];
    assign idle_o  = ~|busy;
    assign err_o   = err_q;

    always_comb begin
        ptr_d      = ptr_q;
        cred_d     = cred_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        err_d      = (|underflow) | bad_id;
        if (accept) begin
            lock_d = 1'b0;
            if ((sel == ptr_q) && (cred_q != '0)) begin
                cred_d = cred_q - ArbWeightW'(1);
            end else begin
                ptr_d  = sel;
                cred_d = eff_weight(Weights[sel*ArbWeightW +: ArbWeightW]) - ArbWeightW'(1);
            end
        end else if (valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            cred_q     <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            cred_q     <= cred_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

endmodule
